// File: rtl/mult_accumulator.sv
// mult_accumulator
// ----------------
// Sits downstream of a fixed-latency pipelined multiplier. It watches the
// multiplier's start strobe and counts out the calculation latency. It then
// samples the product and adds NUM_TERMS products into a saturating sum. The
// finished sum is offered on a valid/ready handshake.
//
// Ports
//   clk        : system clock, rising edge
//   rst        : asynchronous active-high reset
//   start_in   : start strobe shared with the multiplier
//   c_in       : unsigned multiplier product (PROD_W bits)
//   clear      : synchronous abort; zeroes the sum and returns to IDLE
//   acc_out    : accumulated sum (ACC_W bits), saturates at all ones
//   acc_valid  : acc_out holds a completed sum
//   acc_ready  : downstream accepts acc_out
//   overflow   : sticky flag, saturation happened in the current sum
//   busy       : high whenever the block is not IDLE
//   term_count : number of products accumulated so far
module mult_accumulator #(
    parameter int PROD_W      = 8,
    parameter int ACC_W       = 12,
    parameter int CALC_CYCLES = 16,
    parameter int NUM_TERMS   = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start_in,
    input  logic [PROD_W-1:0]                  c_in,
    input  logic                               clear,
    output logic [ACC_W-1:0]                   acc_out,
    output logic                               acc_valid,
    input  logic                               acc_ready,
    output logic                               overflow,
    output logic                               busy,
    output logic [$clog2(NUM_TERMS+1)-1:0]     term_count
);

    localparam int TC_W  = $clog2(NUM_TERMS + 1);
    // The counter holds values 0..CALC_CYCLES-1. Keep at least one bit for CALC_CYCLES=1.
    localparam int CNT_W = (CALC_CYCLES > 1) ? $clog2(CALC_CYCLES) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic [ACC_W-1:0]  acc_q,   acc_d;
    logic              ovf_q,   ovf_d;
    logic              valid_q, valid_d;
    logic [TC_W-1:0]   tc_q,    tc_d;
    logic [TC_W-1:0]   tc_inc_s;
    logic [ACC_W:0]    sum_s;

    // Next-state logic: clear dominates, then per-state behaviour.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        ovf_d    = ovf_q;
        valid_d  = valid_q;
        tc_d     = tc_q;
        // One extra bit catches the carry-out that triggers saturation.
        sum_s    = {1'b0, acc_q} + {{(ACC_W + 1 - PROD_W){1'b0}}, c_in};
        tc_inc_s = tc_q + TC_W'(1);

        if (clear) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            acc_d   = '0;
            ovf_d   = 1'b0;
            valid_d = 1'b0;
            tc_d    = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_in) begin
                        // Edge k loads CALC_CYCLES-1. The capture happens at edge k+CALC_CYCLES.
                        cnt_d   = CNT_W'(CALC_CYCLES - 1);
                        state_d = S_WAIT;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_WAIT: begin
                    if (cnt_q == '0) begin
                        if (sum_s[ACC_W]) begin
                            acc_d = '1;
                            ovf_d = 1'b1;
                        end else begin
                            acc_d = sum_s[ACC_W-1:0];
                        end
                        tc_d = tc_inc_s;
                        if (tc_inc_s == TC_W'(NUM_TERMS)) begin
                            state_d = S_HOLD;
                            valid_d = 1'b1;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                S_HOLD: begin
                    // A start_in on the handshake edge is deliberately dropped.
                    if (acc_ready) begin
                        state_d = S_IDLE;
                        acc_d   = '0;
                        ovf_d   = 1'b0;
                        valid_d = 1'b0;
                        tc_d    = '0;
                    end else begin
                        state_d = S_HOLD;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    valid_d = 1'b0;
                    tc_d    = '0;
                end
            endcase
        end
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
            tc_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            valid_q <= valid_d;
            tc_q    <= tc_d;
        end
    end

    assign acc_out    = acc_q;
    assign acc_valid  = valid_q;
    assign overflow   = ovf_q;
    assign term_count = tc_q;
    assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_mult_accumulator.sv
// tb_mult_accumulator
// Directed bench for mult_accumulator. Two instances share the same stimulus:
// one with the default 12-bit accumulator, and one with a 9-bit accumulator
// that exercises saturation. Completed sums are predicted by a reference model.
// They are queued when the last term is driven and compared when acc_valid
// is observed.
module tb_mult_accumulator;

    logic        clk;
    logic        rst;
    logic        start_in;
    logic        clear;
    logic        acc_ready;
    logic [7:0]  c_in;

    logic [11:0] acc12;
    logic        v12, o12, b12;
    logic [2:0]  tc12;
    logic [8:0]  acc9;
    logic        v9, o9, b9;
    logic [2:0]  tc9;

    int tests = 0;
    int fails = 0;

    // Reference model state
    int   m12, m9, mtc;
    logic mo12, mo9;
    int   q12[$];
    int   q9[$];

    mult_accumulator u_dut12 (
        .clk(clk), .rst(rst), .start_in(start_in), .c_in(c_in), .clear(clear),
        .acc_out(acc12), .acc_valid(v12), .acc_ready(acc_ready),
        .overflow(o12), .busy(b12), .term_count(tc12)
    );

    mult_accumulator #(.ACC_W(9)) u_dut9 (
        .clk(clk), .rst(rst), .start_in(start_in), .c_in(c_in), .clear(clear),
        .acc_out(acc9), .acc_valid(v9), .acc_ready(acc_ready),
        .overflow(o9), .busy(b9), .term_count(tc9)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m12 = 0; m9 = 0; mtc = 0; mo12 = 1'b0; mo9 = 1'b0;
    endtask

    task automatic model_add(input int p);
        m12 = m12 + p;
        if (m12 > 4095) begin m12 = 4095; mo12 = 1'b1; end
        m9 = m9 + p;
        if (m9 > 511) begin m9 = 511; mo9 = 1'b1; end
        mtc++;
        if (mtc == 4) begin
            q12.push_back(m12 | (int'(mo12) << 16));
            q9.push_back(m9 | (int'(mo9) << 16));
            model_clear();
        end
    endtask

    // One multiplier operation: start pulse at edge k. c_in carries p only at edge k+off.
    // clear is pulsed at edge k+clr_off (0 = no clear).
    task automatic do_term(input int p, input int off, input int clr_off);
        int cap;
        start_in = 1'b1; c_in = 8'd0; tick();
        start_in = 1'b0;
        check("busy_in_wait", b12, 1);
        for (int e = 1; e <= 16; e++) begin
            c_in  = (e == off) ? 8'(p) : 8'd0;
            clear = (e == clr_off);
            tick();
        end
        c_in = 8'd0; clear = 1'b0;
        if (clr_off != 0) begin
            model_clear();
            check("clrcap_tc", tc12, 0);
            check("clrcap_acc", acc12, 0);
            check("clrcap_busy", b12, 0);
        end else begin
            cap = (off == 16) ? p : 0;
            check("term_count", tc12, 32'(mtc + 1));
            model_add(cap);
            if (mtc != 0) begin
                check("partial_acc12", acc12, 32'(m12));
                check("partial_acc9", acc9, 32'(m9));
                check("partial_ovf9", o9, 32'(mo9));
                check("partial_valid", v12, 0);
            end
        end
    endtask

    // Compare the HOLD outputs with the oldest queued prediction.
    task automatic check_hold();
        check("sb_depth", q12.size(), 1);
        if (q12.size() > 0 && q9.size() > 0) begin
            check("hold_valid12", v12, 1);
            check("hold_valid9", v9, 1);
            check("hold_acc12", acc12, q12[0] & 32'hFFFF);
            check("hold_ovf12", o12, q12[0] >> 16);
            check("hold_acc9", acc9, q9[0] & 32'hFFFF);
            check("hold_ovf9", o9, q9[0] >> 16);
            check("hold_tc", tc9, 4);
            check("hold_busy", b12, 1);
        end
    endtask

    // acc_ready must already be high. Hand the result over and confirm the return to IDLE.
    task automatic handshake();
        tick();
        check("hs_valid", v12, 0);
        check("hs_acc12", acc12, 0);
        check("hs_ovf12", o12, 0);
        check("hs_acc9", acc9, 0);
        check("hs_ovf9", o9, 0);
        check("hs_tc", tc12, 0);
        check("hs_busy", b12, 0);
        check("hs_busy9", b9, 0);
        if (q12.size() > 0) void'(q12.pop_front());
        if (q9.size() > 0) void'(q9.pop_front());
    endtask

    initial begin
        rst = 1'b1; start_in = 1'b0; clear = 1'b0; acc_ready = 1'b0; c_in = 8'd0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        check("rst_acc", acc12, 0);
        check("rst_valid", v12, 0);
        check("rst_ovf", o12, 0);
        check("rst_busy", b12, 0);
        check("rst_tc", tc12, 0);
        rst = 1'b0;
        tick();

        // Four products 15+63+196+4 = 278.
        acc_ready = 1'b1;
        do_term(15, 16, 0);
        do_term(63, 16, 0);
        do_term(196, 16, 0);
        do_term(4, 16, 0);
        check_hold();
        handshake();

        // Latency: 0xFF at k+16 is captured, 0xFF at k+15 is not.
        do_term(255, 16, 0);
        do_term(255, 15, 0);
        do_term(1, 16, 0);
        do_term(1, 16, 0);
        check_hold();
        handshake();

        // Saturation on the 9-bit instance, followed by backpressure in HOLD.
        do_term(225, 16, 0);
        do_term(225, 16, 0);
        do_term(225, 16, 0);
        check("sat9_acc", acc9, 511);
        check("sat9_ovf", o9, 1);
        acc_ready = 1'b0;
        do_term(225, 16, 0);
        for (int i = 0; i < 10; i++) begin
            start_in = (i % 2 == 0);
            tick();
            check_hold();
        end
        acc_ready = 1'b1;
        start_in = 1'b1;
        handshake();
        start_in = 1'b0;

        // Asynchronous reset five edges into WAIT of term 2.
        do_term(3, 16, 0);
        start_in = 1'b1; tick(); start_in = 1'b0;
        repeat (5) tick();
        #2 rst = 1'b1;
        #1;
        check("arst_acc", acc12, 0);
        check("arst_tc", tc12, 0);
        check("arst_busy", b12, 0);
        check("arst_valid", v12, 0);
        check("arst_ovf", o12, 0);
        check("arst_acc9", acc9, 0);
        rst = 1'b0;
        model_clear();
        do_term(16, 16, 0);
        do_term(16, 16, 0);
        do_term(16, 16, 0);
        do_term(16, 16, 0);
        check_hold();
        handshake();

        // clear after two terms, then clear on a capture edge.
        do_term(10, 16, 0);
        do_term(20, 16, 0);
        clear = 1'b1; tick(); clear = 1'b0;
        model_clear();
        check("clr_acc", acc12, 0);
        check("clr_tc", tc12, 0);
        check("clr_busy", b12, 0);
        do_term(7, 16, 0);
        do_term(9, 16, 16);
        do_term(5, 16, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
